// File: rtl/dcache_ctrl_if.sv
// Bus bundle for the direct-mapped data cache controller: CPU side, backing memory side
// and the external 32-word data store. slave = cache controller, master = environment.
interface dcache_ctrl_if;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic [4:0]  ram_raddr;
  logic [4:0]  ram_waddr;
  logic [31:0] ram_datain;
  logic        ram_we;
  logic [31:0] ram_dataout;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata, mem_ack, ram_dataout,
    output cpu_rdata, cpu_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
           ram_raddr, ram_waddr, ram_datain, ram_we
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata, mem_ack, ram_dataout,
    input  cpu_rdata, cpu_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
           ram_raddr, ram_waddr, ram_datain, ram_we
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller:
// 4 lines x 8 words x 32 bits, tag = addr[31:7], line = addr[6:5], word = addr[4:2].
//
// Handshakes: cpu_rd/cpu_wr are levels held by the CPU until a one-cycle cpu_ready pulse;
// mem_rd/mem_wr are levels held by the cache until mem_ack, and every cycle with mem_ack
// high transfers exactly one word. cpu_rdata is the data-store output, valid with cpu_ready.
module dcache_ctrl (
  input  logic                clk,
  input  logic                reset_n,
  dcache_ctrl_if.slave        bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_RDWAIT = 3'd2,
    S_FILL   = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      r_state;
  logic [24:0] r_tag_q [4];
  logic [3:0]  r_valid;
  logic [2:0]  r_cnt;
  logic        r_rdwait;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_wr;

  logic        r_cpu_ready;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [4:0]  r_ram_raddr;
  logic [4:0]  r_ram_waddr;
  logic [31:0] r_ram_datain;
  logic        r_ram_we;

  logic [24:0] w_tag;
  logic [1:0]  w_line;
  logic [2:0]  w_word;
  logic        w_hit;
  logic        w_fill_done;
  logic        w_unused_addr_lsb;

  assign w_tag             = r_addr[29:5];
  assign w_line            = r_addr[4:3];
  assign w_word            = r_addr[2:0];
  assign w_hit             = r_valid[w_line] && (r_tag_q[w_line] == w_tag);
  assign w_fill_done       = (r_state == S_FILL) && bus.mem_ack && (r_cnt == 3'd7);
  assign w_unused_addr_lsb = ^bus.cpu_addr[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 4'b0;
      r_cnt        <= 3'd0;
      r_rdwait     <= 1'b0;
      r_addr       <= 30'd0;
      r_wdata      <= 32'd0;
      r_is_wr      <= 1'b0;
      r_cpu_ready  <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_ram_raddr  <= 5'd0;
      r_ram_waddr  <= 5'd0;
      r_ram_datain <= 32'd0;
      r_ram_we     <= 1'b0;
    end else begin
      r_ram_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_rd || bus.cpu_wr) begin
            r_addr      <= bus.cpu_addr[31:2];
            r_wdata     <= bus.cpu_wdata;
            r_is_wr     <= bus.cpu_wr;
            r_ram_raddr <= bus.cpu_addr[6:2];
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (r_is_wr) begin
            // Write-through: update the store only on a hit, memory always.
            if (w_hit) begin
              r_ram_we     <= 1'b1;
              r_ram_waddr  <= {w_line, w_word};
              r_ram_datain <= r_wdata;
            end
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= {r_addr, 2'b00};
            r_mem_wdata <= r_wdata;
            r_state     <= S_WRITE;
          end else if (w_hit) begin
            r_rdwait <= 1'b0;
            r_state  <= S_RDWAIT;
          end else begin
            r_mem_rd   <= 1'b1;
            r_cnt      <= 3'd0;
            r_mem_addr <= {w_tag, w_line, 3'd0, 2'b00};
            r_state    <= S_FILL;
          end
        end
        S_RDWAIT: begin
          // Two cycles here so the registered store output is settled when cpu_ready rises.
          if (r_rdwait) begin
            r_cpu_ready <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_rdwait <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            r_ram_we     <= 1'b1;
            r_ram_waddr  <= {w_line, r_cnt};
            r_ram_datain <= bus.mem_rdata;
            r_cnt        <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_mem_rd        <= 1'b0;
              r_valid[w_line] <= 1'b1;
              r_state         <= S_LOOKUP;
            end else begin
              r_mem_addr <= {w_tag, w_line, r_cnt + 3'd1, 2'b00};
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_mem_wr    <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag_q[w_line] <= w_tag;
    end
  end

  assign bus.cpu_rdata  = bus.ram_dataout;
  assign bus.cpu_ready  = r_cpu_ready;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.ram_raddr  = r_ram_raddr;
  assign bus.ram_waddr  = r_ram_waddr;
  assign bus.ram_datain = r_ram_datain;
  assign bus.ram_we     = r_ram_we;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: backing memory and data store models, scoreboard queues
// for CPU responses, memory transfers and data-store writes, popped by a negedge monitor.
module tb_dcache_ctrl;

  logic       clk;
  logic       reset_n;
  logic [2:0] dbg_state;

  dcache_ctrl_if bus();

  dcache_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];      // {is_read, rdata}
  logic [64:0] exp_mem_q[$];  // {is_write, addr, wdata}
  logic [36:0] exp_ram_q[$];  // {waddr, datain}
  int checks = 0;
  int errors = 0;
  int fill_acks = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] ram_mem [0:31];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {16'hA5A5, a[15:0]};
  endfunction

  // ---------------- data store model: registered read ----------------
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_waddr] <= bus.ram_datain;
    bus.ram_dataout <= ram_mem[bus.ram_raddr];
  end

  // ---------------- backing memory: acks every other cycle ----------------
  always @(posedge clk) begin
    #2;
    if (reset_n && (bus.mem_rd || bus.mem_wr) && bus.mem_ack !== 1'b1) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bmem_rd(bus.mem_addr);
      if (bus.mem_wr) bmem[bus.mem_addr] = bus.mem_wdata;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [64:0] m;
    logic [36:0] r;
    if (reset_n) begin
      if (bus.cpu_ready) begin
        if (exp_q.size() == 0) flag_fail("cpu_ready_unexpected");
        else begin
          e = exp_q.pop_front();
          if (e[32]) check("cpu_rdata", 72'(bus.cpu_rdata), 72'(e[31:0]));
        end
      end
      if (bus.mem_ack && (bus.mem_rd || bus.mem_wr)) begin
        if (bus.mem_rd) fill_acks++;
        check("mem_rd_wr_exclusive", 72'(bus.mem_rd & bus.mem_wr), 72'(0));
        if (exp_mem_q.size() == 0) flag_fail("mem_xfer_unexpected");
        else begin
          m = exp_mem_q.pop_front();
          check("mem_xfer", 72'({bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 32'd0}),
                72'(m));
        end
      end
      if (bus.ram_we) begin
        if (exp_ram_q.size() == 0) flag_fail("ram_we_unexpected");
        else begin
          r = exp_ram_q.pop_front();
          check("ram_write", 72'({bus.ram_waddr, bus.ram_datain}), 72'(r));
        end
      end
    end
  end

  // ---------------- expectation helpers ----------------
  task automatic exp_fill(input logic [31:0] addr);
    logic [31:0] a;
    logic [2:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      a = {addr[31:5], w, 2'b00};
      exp_mem_q.push_back({1'b0, a, 32'd0});
      exp_ram_q.push_back({addr[6:5], w, bmem_rd(a)});
    end
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic hit);
    exp_mem_q.push_back({1'b1, addr[31:2], 2'b00, data});
    if (hit) exp_ram_q.push_back({addr[6:2], data});
  endtask

  // ---------------- driver ----------------
  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input int exp_lat);
    int   cyc;
    logic seen;
    exp_q.push_back({rd & ~wr, exp_rdata});
    @(negedge clk);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      // Request was taken at the first edge; later changes must not matter.
      if (cyc == 1) begin bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; end
      @(negedge clk);
      seen = bus.cpu_ready;
    end
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    if (!seen) begin
      flag_fail("cpu_ready_timeout");
      exp_q.delete(); exp_mem_q.delete(); exp_ram_q.delete();
    end else if (exp_lat >= 0) begin
      check("hit_latency", 72'(cyc - 1), 72'(exp_lat));
    end
    @(negedge clk);
    @(negedge clk);
    check("cpu_q_drained", 72'(exp_q.size()), 72'(0));
    check("mem_q_drained", 72'(exp_mem_q.size()), 72'(0));
    check("ram_q_drained", 72'(exp_ram_q.size()), 72'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_state"},      72'(dbg_state), 72'(0));
    check({tag, "_cpu_ready"},  72'(bus.cpu_ready), 72'(0));
    check({tag, "_mem_rd"},     72'(bus.mem_rd), 72'(0));
    check({tag, "_mem_wr"},     72'(bus.mem_wr), 72'(0));
    check({tag, "_mem_addr"},   72'(bus.mem_addr), 72'(0));
    check({tag, "_mem_wdata"},  72'(bus.mem_wdata), 72'(0));
    check({tag, "_ram_we"},     72'(bus.ram_we), 72'(0));
    check({tag, "_ram_raddr"},  72'(bus.ram_raddr), 72'(0));
    check({tag, "_ram_waddr"},  72'(bus.ram_waddr), 72'(0));
    check({tag, "_ram_datain"}, 72'(bus.ram_datain), 72'(0));
  endtask

  task automatic read_with_reset_mid_fill(input logic [31:0] addr);
    int base;
    int cyc;
    exp_fill(addr);
    base = fill_acks;
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = addr; bus.cpu_wdata = 32'd0;
    cyc = 0;
    while ((fill_acks - base) < 4 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("acks_before_reset", 72'(fill_acks - base), 72'(4));
    reset_n = 1'b0;
    bus.cpu_rd = 1'b0;
    #1;
    check_outputs_zero("midfill_reset");
    exp_q.delete(); exp_mem_q.delete(); exp_ram_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Cold read: full line fill 0x100..0x11C, then served through the hit path.
    exp_fill(32'h0000_0104);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hA5A5_0104, -1);
    // Repeat read in the same line: no memory traffic, 3 cycles.
    cpu_req(1'b1, 1'b0, 32'h0000_0108, 32'd0, 32'hA5A5_0108, 3);
    // Write hit: store index 1 and memory both updated.
    exp_write(32'h0000_0104, 32'hDEAD_BEEF, 1'b1);
    cpu_req(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, -1);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 3);
    // Both strobes high behaves as a write.
    exp_write(32'h0000_0108, 32'h0BAD_F00D, 1'b1);
    cpu_req(1'b1, 1'b1, 32'h0000_0108, 32'h0BAD_F00D, 32'd0, -1);
    cpu_req(1'b1, 1'b0, 32'h0000_0108, 32'd0, 32'h0BAD_F00D, 3);
    // Write miss: memory only, then the read misses and fills.
    exp_write(32'h0000_0300, 32'h1234_5678, 1'b0);
    cpu_req(1'b0, 1'b1, 32'h0000_0300, 32'h1234_5678, 32'd0, -1);
    exp_fill(32'h0000_0300);
    cpu_req(1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'h1234_5678, -1);
    // Line 0 conflicts: 0x104 refills, 0x1104 replaces it, 0x104 refills again.
    exp_fill(32'h0000_0104);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, -1);
    exp_fill(32'h0000_1104);
    cpu_req(1'b1, 1'b0, 32'h0000_1104, 32'd0, 32'hA5A5_1104, -1);
    exp_fill(32'h0000_0104);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, -1);
    // Another line leaves line 0 untouched.
    exp_fill(32'h0000_01E4);
    cpu_req(1'b1, 1'b0, 32'h0000_01E4, 32'd0, 32'hA5A5_01E4, -1);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 3);
    // Reset after the 4th fill ack: every line invalid afterwards.
    read_with_reset_mid_fill(32'h0000_1104);
    exp_fill(32'h0000_0104);
    cpu_req(1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, -1);
    exp_fill(32'h0000_01E4);
    cpu_req(1'b1, 1'b0, 32'h0000_01E4, 32'd0, 32'hA5A5_01E4, -1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "global timeout");
  end

endmodule
